// File: rtl/bsg_manycore_proc_return_dispatch.sv
// bsg_manycore_proc_return_dispatch
//
// Steers packets returned by the endpoint to one of num_dest_p response
// channels (int RF, float RF, ifetch, ...). Each channel has a small FIFO, a
// force-writeback indication, and an outstanding-request counter that feeds
// fence/idle detection and protocol error checking.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   returned_*_i            returned packet from the endpoint (valid, data,
//                           register id, channel, endpoint FIFO full)
//   returned_yumi_o         returned packet consumed this cycle
//   issue_v_i/issue_dest_i  remote load issued to a channel this cycle
//   issue_ready_o           per-channel: another issue is allowed
//   resp_v_o/data/rd/force  per-channel head of buffer, packed at slice d
//   resp_yumi_i             per-channel: core consumed the head
//   outstanding_o           per-channel outstanding count, packed at slice d
//   idle_o                  all counts zero and all buffers empty
//   error_o                 sticky protocol error
module bsg_manycore_proc_return_dispatch #(
  parameter int data_width_p   = 32,
  parameter int reg_id_width_p = 5,
  parameter int num_dest_p     = 3,
  parameter int fifo_els_p     = 2,
  parameter int max_out_p      = 16,
  parameter int dest_width_lp  = (num_dest_p > 1) ? $clog2(num_dest_p) : 1,
  parameter int cnt_width_lp   = $clog2(max_out_p + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 returned_v_i,
  input  logic [data_width_p-1:0]              returned_data_i,
  input  logic [reg_id_width_p-1:0]            returned_reg_id_i,
  input  logic [dest_width_lp-1:0]             returned_dest_i,
  input  logic                                 returned_fifo_full_i,
  output logic                                 returned_yumi_o,
  input  logic                                 issue_v_i,
  input  logic [dest_width_lp-1:0]             issue_dest_i,
  output logic [num_dest_p-1:0]                issue_ready_o,
  output logic [num_dest_p-1:0]                resp_v_o,
  output logic [num_dest_p*data_width_p-1:0]   resp_data_o,
  output logic [num_dest_p*reg_id_width_p-1:0] resp_rd_o,
  output logic [num_dest_p-1:0]                resp_force_o,
  input  logic [num_dest_p-1:0]                resp_yumi_i,
  output logic [num_dest_p*cnt_width_lp-1:0]   outstanding_o,
  output logic                                 idle_o,
  output logic                                 error_o
);

  localparam int ptr_width_lp = $clog2(fifo_els_p);
  localparam int occ_width_lp = $clog2(fifo_els_p + 1);

  logic                  ret_dest_valid;
  logic                  issue_dest_valid;
  logic                  full_sel;
  logic [num_dest_p-1:0] full_vec;
  logic [num_dest_p-1:0] busy_vec;
  logic [num_dest_p-1:0] cnt_err_vec;
  logic                  error_reg;

  // Dest values at or above num_dest_p exist only when num_dest_p is not a
  // power of two; such packets are swallowed and flagged.
  assign ret_dest_valid   = int'(returned_dest_i) < num_dest_p;
  assign issue_dest_valid = int'(issue_dest_i) < num_dest_p;

  // Channel select is resolved with a loop so an out-of-range dest never
  // indexes past full_vec.
  always_comb begin
    full_sel = 1'b0;
    for (int d = 0; d < num_dest_p; d++) begin
      if (returned_dest_i == dest_width_lp'(d)) full_sel = full_vec[d];
    end
  end

  // Acceptance looks only at registered occupancy, so a same-cycle dequeue
  // cannot open a slot in a full buffer.
  assign returned_yumi_o = returned_v_i & (~ret_dest_valid | ~full_sel);

  genvar gi;
  for (gi = 0; gi < num_dest_p; gi++) begin : g_ch
    logic [data_width_p-1:0]   data_mem [fifo_els_p];
    logic [reg_id_width_p-1:0] rd_mem   [fifo_els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [occ_width_lp-1:0]   occ_reg;
    logic [cnt_width_lp-1:0]   cnt_reg;
    logic                      hit_ret, enq, deq, inc_req, dec_req;
    logic                      at_max, at_zero;

    assign hit_ret  = ret_dest_valid & (returned_dest_i == dest_width_lp'(gi));
    assign enq      = returned_yumi_o & hit_ret;
    assign deq      = resp_yumi_i[gi] & (occ_reg != '0);
    assign full_vec[gi] = (occ_reg == occ_width_lp'(fifo_els_p));

    // Storage has no reset: occupancy alone decides what is valid. The head
    // is read combinationally so an accepted packet is visible next cycle.
    always_ff @(posedge clk_i) begin
      if (enq) begin
        data_mem[wr_ptr_reg] <= returned_data_i;
        rd_mem[wr_ptr_reg]   <= returned_reg_id_i;
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        occ_reg    <= '0;
      end else begin
        if (enq) wr_ptr_reg <= (wr_ptr_reg == ptr_width_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
        if (deq) rd_ptr_reg <= (rd_ptr_reg == ptr_width_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_reg + 1'b1;
        if (enq & ~deq)      occ_reg <= occ_reg + 1'b1;
        else if (deq & ~enq) occ_reg <= occ_reg - 1'b1;
      end
    end

    // Issue and return on the same channel cancel; a lone issue at max or a
    // lone return at zero leaves the count where it is and raises an error.
    assign inc_req = issue_v_i & (issue_dest_i == dest_width_lp'(gi));
    assign dec_req = enq;
    assign at_max  = (cnt_reg == cnt_width_lp'(max_out_p));
    assign at_zero = (cnt_reg == '0);
    assign cnt_err_vec[gi] = (inc_req & ~dec_req & at_max) | (dec_req & ~inc_req & at_zero);

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_reg <= '0;
      end else if (inc_req & ~dec_req & ~at_max) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (dec_req & ~inc_req & ~at_zero) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end

    assign resp_v_o[gi]      = (occ_reg != '0);
    assign resp_force_o[gi]  = resp_v_o[gi] &
                               (full_vec[gi] | (returned_v_i & hit_ret & returned_fifo_full_i));
    assign issue_ready_o[gi] = ~at_max;
    assign busy_vec[gi]      = (occ_reg != '0) | ~at_zero;

    assign resp_data_o[gi*data_width_p +: data_width_p]     = data_mem[rd_ptr_reg];
    assign resp_rd_o[gi*reg_id_width_p +: reg_id_width_p]   = rd_mem[rd_ptr_reg];
    assign outstanding_o[gi*cnt_width_lp +: cnt_width_lp]   = cnt_reg;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_reg <= 1'b0;
    end else begin
      error_reg <= error_reg | (|cnt_err_vec)
                 | (returned_v_i & ~ret_dest_valid)
                 | (issue_v_i & ~issue_dest_valid);
    end
  end

  assign error_o = error_reg;
  assign idle_o  = ~(|busy_vec);

endmodule

// File: tb/tb_bsg_manycore_proc_return_dispatch.sv
module tb_bsg_manycore_proc_return_dispatch;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int ND = 3;
  localparam int CW = 5;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          returned_v_i;
  logic [DW-1:0] returned_data_i;
  logic [RW-1:0] returned_reg_id_i;
  logic [1:0]    returned_dest_i;
  logic          returned_fifo_full_i;
  logic          returned_yumi_o;
  logic          issue_v_i;
  logic [1:0]    issue_dest_i;
  logic [ND-1:0] issue_ready_o;
  logic [ND-1:0] resp_v_o;
  logic [ND*DW-1:0] resp_data_o;
  logic [ND*RW-1:0] resp_rd_o;
  logic [ND-1:0] resp_force_o;
  logic [ND-1:0] resp_yumi_i;
  logic [ND*CW-1:0] outstanding_o;
  logic          idle_o;
  logic          error_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bsg_manycore_proc_return_dispatch dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .returned_v_i        (returned_v_i),
    .returned_data_i     (returned_data_i),
    .returned_reg_id_i   (returned_reg_id_i),
    .returned_dest_i     (returned_dest_i),
    .returned_fifo_full_i(returned_fifo_full_i),
    .returned_yumi_o     (returned_yumi_o),
    .issue_v_i           (issue_v_i),
    .issue_dest_i        (issue_dest_i),
    .issue_ready_o       (issue_ready_o),
    .resp_v_o            (resp_v_o),
    .resp_data_o         (resp_data_o),
    .resp_rd_o           (resp_rd_o),
    .resp_force_o        (resp_force_o),
    .resp_yumi_i         (resp_yumi_i),
    .outstanding_o       (outstanding_o),
    .idle_o              (idle_o),
    .error_o             (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] dat(input int d);
    return resp_data_o[d*DW +: DW];
  endfunction

  function automatic logic [RW-1:0] rdv(input int d);
    return resp_rd_o[d*RW +: RW];
  endfunction

  function automatic logic [CW-1:0] cnt(input int d);
    return outstanding_o[d*CW +: CW];
  endfunction

  initial begin
    reset_i = 1'b1; returned_v_i = 1'b0; returned_data_i = '0; returned_reg_id_i = '0;
    returned_dest_i = '0; returned_fifo_full_i = 1'b0; issue_v_i = 1'b0; issue_dest_i = '0;
    resp_yumi_i = '0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    #1;
    check("rst_resp_v", resp_v_o, 3'b000);
    check("rst_force", resp_force_o, 3'b000);
    check("rst_yumi", returned_yumi_o, 1'b0);
    check("rst_idle", idle_o, 1'b1);
    check("rst_ready", issue_ready_o, 3'b111);
    check("rst_error", error_o, 1'b0);
    check("rst_outst", outstanding_o, '0);

    // Three loads to ch1, returned in order with the core consuming at once.
    issue_v_i = 1'b1; issue_dest_i = 2'd1;
    repeat (3) tick();
    issue_v_i = 1'b0;
    #1;
    check("t1_cnt3", cnt(1), 5'd3);
    check("t1_busy", idle_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      returned_v_i = 1'b1; returned_dest_i = 2'd1;
      returned_data_i = 32'hA1 + i; returned_reg_id_i = 5'(5 + i);
      #1;
      check("t1_yumi", returned_yumi_o, 1'b1);
      tick();
      resp_yumi_i = 3'b010;
      check("t1_v", resp_v_o, 3'b010);
      check("t1_data", dat(1), 32'hA1 + i);
      check("t1_rd", rdv(1), 5'(5 + i));
      check("t1_cnt", cnt(1), 5'(2 - i));
    end
    returned_v_i = 1'b0;
    tick();
    resp_yumi_i = 3'b000;
    #1;
    check("t1_empty", resp_v_o, 3'b000);
    check("t1_idle", idle_o, 1'b1);

    // ch0 back-pressure: two-deep buffer held full.
    issue_v_i = 1'b1; issue_dest_i = 2'd0;
    repeat (3) tick();
    issue_v_i = 1'b0;
    returned_v_i = 1'b1; returned_dest_i = 2'd0; returned_data_i = 32'hB1; returned_reg_id_i = 5'd1;
    #1 check("t2_yumi1", returned_yumi_o, 1'b1);
    tick();
    returned_data_i = 32'hB2; returned_reg_id_i = 5'd2;
    #1;
    check("t2_yumi2", returned_yumi_o, 1'b1);
    check("t2_noforce", resp_force_o[0], 1'b0);
    tick();
    returned_data_i = 32'hB3; returned_reg_id_i = 5'd3;
    #1;
    check("t2_full_yumi", returned_yumi_o, 1'b0);
    check("t2_force", resp_force_o[0], 1'b1);
    check("t2_head1", dat(0), 32'hB1);
    resp_yumi_i = 3'b001;
    #1 check("t2_deq_yumi", returned_yumi_o, 1'b0);
    tick();
    resp_yumi_i = 3'b000;
    #1;
    check("t2_yumi3", returned_yumi_o, 1'b1);
    check("t2_head2", dat(0), 32'hB2);
    check("t2_force0", resp_force_o[0], 1'b0);
    tick();
    returned_v_i = 1'b0;
    #1;
    check("t2_force2", resp_force_o[0], 1'b1);
    check("t2_cnt0", cnt(0), 5'd0);
    check("t2_head2b", dat(0), 32'hB2);
    resp_yumi_i = 3'b001;
    tick();
    check("t2_head3", dat(0), 32'hB3);
    check("t2_rd3", rdv(0), 5'd3);
    tick();
    resp_yumi_i = 3'b000;
    #1;
    check("t2_empty", resp_v_o, 3'b000);
    check("t2_error", error_o, 1'b0);

    // Same-cycle issue+return on ch2, then interleaved ch0/ch1 returns.
    issue_v_i = 1'b1; issue_dest_i = 2'd2; repeat (4) tick();
    issue_dest_i = 2'd0; repeat (2) tick();
    issue_dest_i = 2'd1; repeat (2) tick();
    issue_dest_i = 2'd2;
    returned_v_i = 1'b1; returned_dest_i = 2'd2; returned_data_i = 32'hC1; returned_reg_id_i = 5'd9;
    #1 check("t3_yumi", returned_yumi_o, 1'b1);
    tick();
    issue_v_i = 1'b0;
    check("t3_cnt4", cnt(2), 5'd4);
    check("t3_head", dat(2), 32'hC1);
    returned_data_i = 32'hC2; returned_reg_id_i = 5'd10; returned_fifo_full_i = 1'b1;
    #1 check("t3_force_ep", resp_force_o[2], 1'b1);
    tick();
    returned_fifo_full_i = 1'b0;
    check("t3_cnt3", cnt(2), 5'd3);
    returned_dest_i = 2'd0; returned_data_i = 32'hD0; tick();
    returned_dest_i = 2'd1; returned_data_i = 32'hE0; tick();
    returned_dest_i = 2'd0; returned_data_i = 32'hD1; returned_reg_id_i = 5'd11; tick();
    returned_dest_i = 2'd1; returned_data_i = 32'hE1; returned_reg_id_i = 5'd12; tick();
    returned_v_i = 1'b0;
    #1;
    check("t3_d0", dat(0), 32'hD0);
    check("t3_e0", dat(1), 32'hE0);
    check("t3_force", resp_force_o, 3'b111);
    check("t3_cnt01", {cnt(0), cnt(1)}, 10'd0);
    resp_yumi_i = 3'b011;
    tick();
    check("t3_d1", dat(0), 32'hD1);
    check("t3_e1", dat(1), 32'hE1);
    check("t3_rd_e1", rdv(1), 5'd12);
    resp_yumi_i = 3'b111;
    tick();
    check("t3_v_ch2", resp_v_o, 3'b100);
    check("t3_c2", dat(2), 32'hC2);
    resp_yumi_i = 3'b100;
    tick();
    resp_yumi_i = 3'b000;
    #1;
    check("t3_empty", resp_v_o, 3'b000);
    check("t3_error", error_o, 1'b0);

    // Saturate ch1 at max_out_p.
    issue_v_i = 1'b1; issue_dest_i = 2'd1;
    repeat (15) tick();
    check("t4_cnt15", cnt(1), 5'd15);
    check("t4_ready15", issue_ready_o[1], 1'b1);
    tick();
    check("t4_cnt16", cnt(1), 5'd16);
    check("t4_ready16", issue_ready_o, 3'b101);
    check("t4_noerr", error_o, 1'b0);
    tick();
    issue_v_i = 1'b0;
    check("t4_cnt_hold", cnt(1), 5'd16);
    check("t4_err", error_o, 1'b1);

    // Invalid return dest.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    check("t5_err_clr", error_o, 1'b0);
    returned_v_i = 1'b1; returned_dest_i = 2'd3; returned_data_i = 32'hFF;
    #1 check("t5_yumi", returned_yumi_o, 1'b1);
    tick();
    returned_v_i = 1'b0;
    check("t5_v", resp_v_o, 3'b000);
    check("t5_err", error_o, 1'b1);
    check("t5_idle", idle_o, 1'b1);
    repeat (2) tick();
    check("t5_sticky", error_o, 1'b1);

    // Asynchronous reset with buffered responses in flight.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    issue_v_i = 1'b1; issue_dest_i = 2'd0;
    repeat (7) tick();
    issue_v_i = 1'b0;
    returned_v_i = 1'b1; returned_dest_i = 2'd0; returned_data_i = 32'hF0;
    tick();
    returned_data_i = 32'hF1;
    tick();
    returned_v_i = 1'b0;
    check("t6_v", resp_v_o, 3'b001);
    check("t6_cnt5", cnt(0), 5'd5);
    #2 reset_i = 1'b1;
    #1;
    check("t6_v_rst", resp_v_o, 3'b000);
    check("t6_outst", outstanding_o, '0);
    check("t6_idle", idle_o, 1'b1);
    check("t6_force", resp_force_o, 3'b000);
    tick();
    reset_i = 1'b0;
    tick();
    check("t6_after", resp_v_o, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
